// File: rtl/frame_config_sequencer.sv
// Assembles 32-bit config stream words into frames and pulses one-hot FrameStrobe.
// Optional FRAME_CHECKSUM_EN adds a trailing wrapping-sum check word per load.
module frame_config_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int NumberOfColumns = 10,
  parameter logic [FrameBitsPerRow-1:0] SYNC_WORD = 32'hFAB0_FAB1
) (
  input  logic                                       CLK,
  input  logic                                       resetn,
  input  logic [FrameBitsPerRow-1:0]                 s_data,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumberOfColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                       ConfigBusy,
  output logic                                       ConfigDone,
  output logic                                       ConfigError
);

  localparam int RW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int CW = (NumberOfColumns > 1) ? $clog2(NumberOfColumns) : 1;
  localparam int NW = $clog2(MaxFramesPerCol + 1);
  localparam int NS = NumberOfColumns * MaxFramesPerCol;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [7:0] COLS8 = 8'(NumberOfColumns);
  localparam logic [7:0] MF8   = 8'(MaxFramesPerCol);

  typedef enum logic [2:0] {
    S_HUNT,
    S_HEADER,
    S_DATA,
`ifdef FRAME_CHECKSUM_EN
    S_CHECK,
`endif
    S_STROBE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [FrameBitsPerRow-1:0] r_rows [NumberOfRows];
  logic [RW-1:0]              r_row;
  logic [FW-1:0]              r_frame;
  logic [NW-1:0]              r_nf;
  logic [CW-1:0]              r_col;
  logic                       r_last;
  logic                       r_ready;
  logic [NS-1:0]              r_strobe;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;
`ifdef FRAME_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] r_sum;
`endif

  logic          w_acc;
  logic          w_sync;
  logic          w_hdr_ok;
  logic          w_last_row;
  logic          w_more;
  logic [SW-1:0] w_sidx;
  logic [NS-1:0] w_onehot;

  assign w_acc      = s_valid & r_ready;
  assign w_sync     = (s_data == SYNC_WORD);
  // Checked at full header width so out-of-range fields never wrap
  assign w_hdr_ok   = (s_data[15:8] < COLS8) &&
                      (s_data[7:0] != 8'd0) &&
                      (s_data[7:0] <= MF8);
  assign w_last_row = (r_row == RW'(NumberOfRows - 1));
  assign w_more     = (NW'(r_frame) + NW'(1)) < r_nf;
  assign w_sidx     = SW'(r_col) * SW'(MaxFramesPerCol) + SW'(r_frame);
  assign w_onehot   = NS'(1) << w_sidx;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= S_HUNT;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HUNT:   if (w_acc && w_sync) w_next = S_HEADER;
      S_HEADER: if (w_acc) w_next = w_hdr_ok ? S_DATA : S_HUNT;
      S_DATA:   if (w_acc && w_last_row) w_next = S_STROBE;
      S_STROBE: begin
        if (w_more)       w_next = S_DATA;
        else if (!r_last) w_next = S_HEADER;
`ifdef FRAME_CHECKSUM_EN
        else              w_next = S_CHECK;
`else
        else              w_next = S_HUNT;
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHECK:  if (w_acc) w_next = S_HUNT;
`endif
      default:  w_next = S_HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NumberOfRows; i++) r_rows[i] <= '0;
      r_row    <= '0;
      r_frame  <= '0;
      r_nf     <= '0;
      r_col    <= '0;
      r_last   <= 1'b0;
      r_ready  <= 1'b0;
      r_strobe <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      // s_ready drops only for the strobe cycle
      r_ready  <= (w_next != S_STROBE);
      r_strobe <= '0;
      unique case (r_state)
        S_HUNT: begin
          if (w_acc && w_sync) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_sum  <= '0;
`endif
          end
        end
        S_HEADER: begin
          if (w_acc) begin
            if (w_hdr_ok) begin
              r_col   <= CW'(s_data[15:8]);
              r_nf    <= NW'(s_data[7:0]);
              r_last  <= s_data[31];
              r_frame <= '0;
              r_row   <= '0;
            end else begin
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_rows[r_row] <= s_data;
`ifdef FRAME_CHECKSUM_EN
            r_sum <= r_sum + s_data;
`endif
            if (w_last_row) r_strobe <= w_onehot;
            else            r_row    <= r_row + RW'(1);
          end
        end
        S_STROBE: begin
          if (w_more) begin
            r_frame <= r_frame + FW'(1);
            r_row   <= '0;
          end
`ifndef FRAME_CHECKSUM_EN
          else if (r_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (w_acc) begin
            r_done <= (s_data == r_sum);
            r_err  <= (s_data != r_sum);
            r_busy <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NumberOfRows; g++) begin : g_fd
    assign FrameData[g*FrameBitsPerRow +: FrameBitsPerRow] = r_rows[g];
  end

  assign s_ready     = r_ready;
  assign FrameStrobe = r_strobe;
  assign ConfigBusy  = r_busy;
  assign ConfigDone  = r_done;
  assign ConfigError = r_err;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: 2 rows, 3 columns, 20 frames/column.
// Build with +define+FRAME_CHECKSUM_EN to exercise the checksum word.
module tb_frame_config_sequencer;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] WA = 32'h1111_0001;
  localparam logic [31:0] WB = 32'h2222_0002;
  localparam logic [31:0] WC = 32'h3333_0003;
  localparam logic [31:0] WD = 32'h4444_0004;
  localparam logic [31:0] WE = 32'h5555_0005;
  localparam logic [31:0] JUNK = 32'h1234_5678;
  localparam logic [59:0] B20 = 60'h0000_0000_0010_0000;
  localparam logic [59:0] B21 = 60'h0000_0000_0020_0000;
  localparam logic [63:0] FD_A  = {32'h0, WA};
  localparam logic [63:0] FD_BA = {WB, WA};
  localparam logic [63:0] FD_BC = {WB, WC};
  localparam logic [63:0] FD_DC = {WD, WC};
  localparam logic [63:0] FD_DE = {WD, WE};

  logic        CLK;
  logic        resetn;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] FrameData;
  logic [59:0] FrameStrobe;
  logic        ConfigBusy;
  logic        ConfigDone;
  logic        ConfigError;

  frame_config_sequencer #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32),
    .NumberOfRows(2),
    .NumberOfColumns(3)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .ConfigBusy(ConfigBusy),
    .ConfigDone(ConfigDone),
    .ConfigError(ConfigError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic [59:0] stb;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] fd;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] dw(input int n, input int r);
    return {8'hA5, 8'h00, 8'(n), 8'(r)};
  endfunction

  function automatic logic [127:0] outs();
    return {s_ready, FrameStrobe, ConfigBusy, ConfigDone, ConfigError, FrameData};
  endfunction

  task automatic add(input logic v, input logic [31:0] d, input logic rdy,
                     input logic [59:0] stb, input logic b, input logic dn,
                     input logic e, input logic [63:0] fd);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.stb = stb;
    t.busy = b; t.done = dn; t.err = e; t.fd = fd;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic send(input logic [31:0] w);
    logic a;
    a = 1'b0;
    s_valid = 1'b1;
    s_data = w;
    for (int k = 0; k < 8 && !a; k++) begin
      a = s_ready;
      @(posedge CLK); #1;
    end
    s_valid = 1'b0;
    chk("send_accept", {127'h0, a}, 128'h1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 resetn = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] sum;
    int idx, nstb, bitn;
    logic acc;

    resetn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    #1;
    chk("reset_outputs", outs(), 128'h0);
    repeat (2) @(posedge CLK);
    #1 resetn = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_reset", {127'h0, s_ready}, 128'h1);

    // Test 1..3 as a cycle table
    add(1, SYNC,  1, 60'h0, 1, 0, 0, 64'h0);
    add(1, 32'h8000_0102, 1, 60'h0, 1, 0, 0, 64'h0);
    add(1, WA,    1, 60'h0, 1, 0, 0, FD_A);
    add(1, WB,    0, B20,   1, 0, 0, FD_BA);
    add(1, WC,    1, 60'h0, 1, 0, 0, FD_BA);
    add(1, WC,    1, 60'h0, 1, 0, 0, FD_BC);
    add(1, WD,    0, B21,   1, 0, 0, FD_DC);
`ifdef FRAME_CHECKSUM_EN
    add(0, 32'h0, 1, 60'h0, 1, 0, 0, FD_DC);
    add(1, WA + WB + WC + WD, 1, 60'h0, 0, 1, 0, FD_DC);
`else
    add(0, 32'h0, 1, 60'h0, 0, 1, 0, FD_DC);
`endif
    add(1, JUNK,  1, 60'h0, 0, 1, 0, FD_DC);
    add(1, JUNK,  1, 60'h0, 0, 1, 0, FD_DC);
    add(1, SYNC,  1, 60'h0, 1, 0, 0, FD_DC);
    add(1, 32'h0000_0301, 1, 60'h0, 0, 0, 1, FD_DC);
    add(1, SYNC,  1, 60'h0, 1, 0, 0, FD_DC);
    add(1, 32'h0000_0000, 1, 60'h0, 0, 0, 1, FD_DC);
    add(1, SYNC,  1, 60'h0, 1, 0, 0, FD_DC);
    add(1, 32'h0000_0015, 1, 60'h0, 0, 0, 1, FD_DC);
    add(1, SYNC,  1, 60'h0, 1, 0, 0, FD_DC);
    add(1, 32'h0000_FF01, 1, 60'h0, 0, 0, 1, FD_DC);
    add(1, SYNC,  1, 60'h0, 1, 0, 0, FD_DC);
    add(1, 32'h0000_0214, 1, 60'h0, 1, 0, 0, FD_DC);
    add(1, WE,    1, 60'h0, 1, 0, 0, FD_DE);

    foreach (tbl[i]) begin
      s_valid = tbl[i].v;
      s_data = tbl[i].d;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].rdy, tbl[i].stb, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].fd});
    end
    s_valid = 1'b0;

    // Test 4: continuous s_valid, col0 then col2, 20 frames each
    do_reset();
    sum = '0;
    q.push_back(SYNC);
    q.push_back(32'h0000_0014);
    for (int n = 0; n < 20; n++)
      for (int r = 0; r < 2; r++) begin
        q.push_back(dw(n, r));
        sum += dw(n, r);
      end
    q.push_back(32'h8000_0214);
    for (int n = 20; n < 40; n++)
      for (int r = 0; r < 2; r++) begin
        q.push_back(dw(n, r));
        sum += dw(n, r);
      end
`ifdef FRAME_CHECKSUM_EN
    q.push_back(sum);
`endif
    idx = 0;
    nstb = 0;
    for (int cyc = 0; cyc < 300 && !ConfigDone; cyc++) begin
      if (idx < q.size()) begin
        s_valid = 1'b1;
        s_data = q[idx];
      end else begin
        s_valid = 1'b0;
      end
      acc = s_valid && s_ready;
      @(posedge CLK); #1;
      if (acc) idx++;
      if (FrameStrobe != '0) begin
        bitn = (nstb < 20) ? nstb : nstb + 20;
        chk($sformatf("t4_strobe%0d", nstb),
            {64'h0, s_ready, FrameStrobe, 3'b0},
            {64'h0, 1'b0, (nstb < 40) ? (60'h1 << bitn) : 60'h0, 3'b0});
        chk($sformatf("t4_data%0d", nstb), {64'h0, FrameData},
            {64'h0, dw(nstb, 1), dw(nstb, 0)});
        nstb++;
      end else begin
        chk("t4_ready_high", {127'h0, s_ready}, 128'h1);
      end
    end
    s_valid = 1'b0;
    chk("t4_strobe_count", 128'(nstb), 128'd40);
    chk("t4_words_used", 128'(idx), 128'(q.size()));
    chk("t4_done", {125'h0, ConfigBusy, ConfigDone, ConfigError}, 128'b010);

    // Test 5: reset while row 1 is pending
    do_reset();
    send(SYNC);
    send(32'h8000_0001);
    send(WA);
    chk("t5_row0", {64'h0, FrameData}, {64'h0, FD_A});
    s_valid = 1'b1;
    s_data = WB;
    #3 resetn = 1'b0;
    #1;
    chk("t5_async_reset", outs(), 128'h0);
    @(posedge CLK); #1 resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      chk("t5_no_strobe", {FrameStrobe, ConfigBusy, FrameData, 3'b0},
          {60'h0, 1'b0, 64'h0, 3'b0});
    end
    s_valid = 1'b0;
    send(SYNC);
    send(32'h8000_0001);
    send(WC);
    send(WD);
    chk("t5_resync_strobe", {3'h0, FrameStrobe, FrameData, 1'b0},
        {3'h0, 60'h1, FD_DC, 1'b0});

`ifdef FRAME_CHECKSUM_EN
    // Test 6: wrong checksum
    do_reset();
    send(SYNC);
    send(32'h8000_0102);
    send(WA);
    send(WB);
    send(WC);
    send(WD);
    send(WA + WB + WC + WD + 32'd1);
    chk("t6_bad_sum", {125'h0, ConfigBusy, ConfigDone, ConfigError}, 128'b001);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
